// File: rtl/fir_stream_driver.sv
// Collects SAMPLES_NUM samples into a packed batch, launches the filter, and streams results out MSB slot first.
// Start pulse 1 cycle after the last sample when the filter is idle; first result 1 cycle after firDoneIn.
// Upstream stalls outside COLLECT; EMIT holds its slot while resultReadyIn is low; a stuck filter trips the watchdog.
module fir_stream_driver #(
    parameter int SAMPLES_NUM    = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clkIn,
    input  logic                      nResetIn,
    input  logic                      sampleValidIn,
    input  logic [15:0]               sampleIn,
    output logic                      sampleReadyOut,
    output logic                      firStartOut,
    output logic [16*SAMPLES_NUM-1:0] firDataOut,
    input  logic                      firBusyIn,
    input  logic                      firDoneIn,
    input  logic [32*SAMPLES_NUM-1:0] firResultIn,
    output logic                      resultValidOut,
    output logic [31:0]               resultOut,
    input  logic                      resultReadyIn,
    output logic                      timeoutOut
);

    localparam int CNT_W = (SAMPLES_NUM > 1) ? $clog2(SAMPLES_NUM) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES_NUM - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        COLLECT   = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        EMIT      = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_ready_en;
    logic [CNT_W-1:0]          r_sample_cnt;
    logic [CNT_W-1:0]          r_emit_idx;
    logic [WD_W-1:0]           r_wd;
    logic [16*SAMPLES_NUM-1:0] r_data;
    logic [32*SAMPLES_NUM-1:0] r_result;
    logic                      r_timeout;

    logic                      w_accept;
    logic                      w_start;
    logic                      w_capture;
    logic                      w_expire;
    logic                      w_emit_xfer;
    logic [CNT_W-1:0]          w_slot;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_start     = 1'b0;
        w_capture   = 1'b0;
        w_expire    = 1'b0;
        w_emit_xfer = 1'b0;
        case (r_state)
            COLLECT: begin
                w_accept = sampleValidIn & r_ready_en;
                if (w_accept && r_sample_cnt == CNT_LAST)
                    w_state_nxt = START;
            end
            START: begin
                if (!firBusyIn && !firDoneIn) begin
                    w_start     = 1'b1;
                    w_state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // done beats a coincident watchdog expiry
                if (firDoneIn) begin
                    w_capture   = 1'b1;
                    w_state_nxt = EMIT;
                end else if (r_wd == WD_LAST) begin
                    w_expire    = 1'b1;
                    w_state_nxt = COLLECT;
                end
            end
            EMIT: begin
                if (resultReadyIn) begin
                    w_emit_xfer = 1'b1;
                    if (r_emit_idx == CNT_LAST)
                        w_state_nxt = COLLECT;
                end
            end
            default: w_state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clkIn or negedge nResetIn) begin
        if (!nResetIn) begin
            r_state      <= COLLECT;
            r_ready_en   <= 1'b0;
            r_sample_cnt <= '0;
            r_emit_idx   <= '0;
            r_wd         <= '0;
            r_data       <= '0;
            r_result     <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ready_en <= 1'b1;
            if (w_accept) begin
                r_data[16*r_sample_cnt +: 16] <= sampleIn;
                if (r_sample_cnt == CNT_LAST)
                    r_sample_cnt <= '0;
                else
                    r_sample_cnt <= r_sample_cnt + CNT_W'(1);
            end
            if (w_start)
                r_wd <= '0;
            else if (r_state == WAIT_DONE && !w_capture && !w_expire)
                r_wd <= r_wd + WD_W'(1);
            if (w_capture)
                r_result <= firResultIn;
            if (w_expire)
                r_timeout <= 1'b1;
            if (w_emit_xfer) begin
                if (r_emit_idx == CNT_LAST)
                    r_emit_idx <= '0;
                else
                    r_emit_idx <= r_emit_idx + CNT_W'(1);
            end
        end
    end

    // emit index 0 maps to the most significant result slot
    assign w_slot         = CNT_LAST - r_emit_idx;
    assign resultOut      = r_result[32*w_slot +: 32];
    assign sampleReadyOut = (r_state == COLLECT) & r_ready_en;
    assign firStartOut    = w_start;
    assign firDataOut     = r_data;
    assign resultValidOut = (r_state == EMIT);
    assign timeoutOut     = r_timeout;

endmodule

// File: tb/tb_fir_stream_driver.sv
// Directed bench for fir_stream_driver: batch packing, result order, backpressure, busy hold-off, timeout, reset.
module tb_fir_stream_driver;

    logic         clkIn = 1'b0;
    logic         nResetIn = 1'b0;
    logic         sampleValidIn = 1'b0;
    logic [15:0]  sampleIn = '0;
    logic         sampleReadyOut;
    logic         firStartOut;
    logic [63:0]  firDataOut;
    logic         firBusyIn = 1'b0;
    logic         firDoneIn = 1'b0;
    logic [127:0] firResultIn = '0;
    logic         resultValidOut;
    logic [31:0]  resultOut;
    logic         resultReadyIn = 1'b1;
    logic         timeoutOut;

    int vectors = 0;
    int miscompares = 0;

    fir_stream_driver #(.SAMPLES_NUM(4), .TIMEOUT_CYCLES(16)) dut (
        .clkIn         (clkIn),
        .nResetIn      (nResetIn),
        .sampleValidIn (sampleValidIn),
        .sampleIn      (sampleIn),
        .sampleReadyOut(sampleReadyOut),
        .firStartOut   (firStartOut),
        .firDataOut    (firDataOut),
        .firBusyIn     (firBusyIn),
        .firDoneIn     (firDoneIn),
        .firResultIn   (firResultIn),
        .resultValidOut(resultValidOut),
        .resultOut     (resultOut),
        .resultReadyIn (resultReadyIn),
        .timeoutOut    (timeoutOut)
    );

    always #5 clkIn = ~clkIn;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkIn);
        @(negedge clkIn);
        #1;
    endtask

    // leaves the bench in the START cycle, #1 after negedge
    task automatic send_batch(input logic [63:0] batch);
        logic [63:0] b;
        b = batch;
        for (int i = 0; i < 4; i++) begin
            sampleValidIn = 1'b1;
            sampleIn      = b[16*i +: 16];
            #1;
            chk("sample_ready", {127'd0, sampleReadyOut}, 128'd1);
            tick();
        end
        sampleValidIn = 1'b0;
        #1;
    endtask

    // pulse done from a WAIT_DONE cycle, then expect four slots with ready held high
    task automatic done_and_emit(input logic [127:0] res);
        logic [127:0] r;
        r = res;
        firDoneIn   = 1'b1;
        firResultIn = r;
        tick();
        firDoneIn   = 1'b0;
        firResultIn = '0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("emit_valid", {127'd0, resultValidOut}, 128'd1);
            chk("emit_data", {96'd0, resultOut}, {96'd0, r[127-32*i -: 32]});
            tick();
        end
        chk("emit_end_ready", {127'd0, sampleReadyOut}, 128'd1);
        chk("emit_end_valid", {127'd0, resultValidOut}, 128'd0);
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_ready", {127'd0, sampleReadyOut}, 128'd0);
        chk("rst_start", {127'd0, firStartOut}, 128'd0);
        chk("rst_valid", {127'd0, resultValidOut}, 128'd0);
        chk("rst_timeout", {127'd0, timeoutOut}, 128'd0);
        chk("rst_data", {64'd0, firDataOut}, 128'd0);
        chk("rst_result", {96'd0, resultOut}, 128'd0);
        @(negedge clkIn);
        nResetIn = 1'b1;
        #1;
        chk("rel_ready_before_edge", {127'd0, sampleReadyOut}, 128'd0);
        tick();
        chk("rel_ready_after_edge", {127'd0, sampleReadyOut}, 128'd1);

        // done pulse while collecting is ignored
        firDoneIn = 1'b1;
        firResultIn = 128'hDEAD;
        tick();
        firDoneIn = 1'b0;
        #1;
        chk("stray_done_valid", {127'd0, resultValidOut}, 128'd0);

        // basic batch and result ordering
        send_batch(64'h0004_0003_0002_0001);
        chk("b1_start", {127'd0, firStartOut}, 128'd1);
        chk("b1_data", {64'd0, firDataOut}, {64'd0, 64'h0004_0003_0002_0001});
        chk("b1_ready_low", {127'd0, sampleReadyOut}, 128'd0);
        tick();
        chk("b1_start_once", {127'd0, firStartOut}, 128'd0);
        chk("b1_data_hold", {64'd0, firDataOut}, {64'd0, 64'h0004_0003_0002_0001});
        tick();
        tick();
        done_and_emit(128'h11111111_22222222_33333333_44444444);

        // busy hold-off then result backpressure
        firBusyIn = 1'b1;
        send_batch(64'h8000_7FFF_FFFF_1234);
        for (int i = 0; i < 10; i++) begin
            chk("busy_no_start", {127'd0, firStartOut}, 128'd0);
            tick();
        end
        firBusyIn = 1'b0;
        #1;
        chk("busy_start", {127'd0, firStartOut}, 128'd1);
        chk("b2_data", {64'd0, firDataOut}, {64'd0, 64'h8000_7FFF_FFFF_1234});
        tick();
        resultReadyIn = 1'b0;
        firDoneIn   = 1'b1;
        firResultIn = 128'hAAAA0001_BBBB0002_CCCC0003_DDDD0004;
        tick();
        firDoneIn   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {127'd0, resultValidOut}, 128'd1);
            chk("bp_data", {96'd0, resultOut}, {96'd0, 32'hAAAA0001});
            tick();
        end
        resultReadyIn = 1'b1;
        #1;
        chk("bp_slot0", {96'd0, resultOut}, {96'd0, 32'hAAAA0001});
        tick();
        chk("bp_slot1", {96'd0, resultOut}, {96'd0, 32'hBBBB0002});
        tick();
        chk("bp_slot2", {96'd0, resultOut}, {96'd0, 32'hCCCC0003});
        tick();
        chk("bp_slot3", {96'd0, resultOut}, {96'd0, 32'hDDDD0004});
        tick();
        chk("bp_end_ready", {127'd0, sampleReadyOut}, 128'd1);

        // done in the final watchdog cycle wins
        send_batch(64'h0DEF_0ABC_0456_0123);
        chk("tie_start", {127'd0, firStartOut}, 128'd1);
        for (int i = 0; i < 16; i++) tick();
        done_and_emit(128'h01234567_89ABCDEF_FEDCBA98_76543210);
        chk("tie_no_timeout", {127'd0, timeoutOut}, 128'd0);

        // watchdog expiry
        send_batch(64'h4444_3333_2222_1111);
        chk("to_start", {127'd0, firStartOut}, 128'd1);
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("to_pending", {126'd0, timeoutOut, sampleReadyOut}, 128'd0);
        end
        tick();
        chk("to_flag", {127'd0, timeoutOut}, 128'd1);
        chk("to_ready", {127'd0, sampleReadyOut}, 128'd1);
        firDoneIn = 1'b1;
        tick();
        firDoneIn = 1'b0;
        #1;
        chk("to_late_done", {127'd0, resultValidOut}, 128'd0);

        // next batch after timeout proceeds normally
        send_batch(64'h0008_0007_0006_0005);
        chk("post_to_start", {127'd0, firStartOut}, 128'd1);
        chk("post_to_data", {64'd0, firDataOut}, {64'd0, 64'h0008_0007_0006_0005});
        tick();
        done_and_emit(128'hCAFEF00D_00000000_FFFFFFFF_80000001);
        chk("to_sticky", {127'd0, timeoutOut}, 128'd1);

        // reset while waiting on the filter
        send_batch(64'h5555_6666_7777_8888);
        tick();
        tick();
        nResetIn = 1'b0;
        #1;
        chk("mid_rst_outputs",
            {15'd0, sampleReadyOut, firStartOut, resultValidOut, timeoutOut, firDataOut, resultOut},
            128'd0);
        firDoneIn = 1'b1;
        firResultIn = 128'h99999999_99999999_99999999_99999999;
        tick();
        firDoneIn = 1'b0;
        #1;
        chk("mid_rst_done_ignored", {126'd0, resultValidOut, sampleReadyOut}, 128'd0);
        nResetIn = 1'b1;
        firDoneIn = 1'b1;
        #1;
        chk("mid_rel_ready_low", {127'd0, sampleReadyOut}, 128'd0);
        tick();
        firDoneIn = 1'b0;
        #1;
        chk("mid_rel_ready", {127'd0, sampleReadyOut}, 128'd1);
        chk("mid_rel_valid", {127'd0, resultValidOut}, 128'd0);
        chk("mid_rel_result", {96'd0, resultOut}, 128'd0);
        chk("mid_rel_timeout", {127'd0, timeoutOut}, 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
